// File: rtl/halfstrip_hit_counter.sv
// halfstrip_hit_counter: per-half-strip onset counters over a programmable bx window.
// It also keeps an event counter and a multi-strip (crosstalk) event counter.
// A registered read port returns the counts by address for the serial register block.
// Optional feature macro: HSCNT_SATFLAG_EN adds a sticky per-strip saturation register,
// which is readable at rd_adr 35/36.
module halfstrip_hit_counter #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      halfstrips,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic [WIN_W-1:0] window,
    input  logic [5:0]       rd_adr,
    output logic [CNT_W-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             any_sat
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r, state_s;
    logic [WIN_W-1:0] win_cnt_r, win_cnt_s;
    logic [31:0]      hs_r;
    logic [31:0]      onset_s;
    logic             multi_s;
    logic             zero_s;
    logic             count_s;
    logic [CNT_W-1:0] cnt_r     [32];
    logic [CNT_W-1:0] cnt_nxt_s [32];
    logic [CNT_W-1:0] evt_cnt_r;
    logic [CNT_W-1:0] multi_cnt_r;
    logic [CNT_W-1:0] rd_s;
    logic [CNT_W-1:0] rd_data_r;
    logic             busy_r;
    logic             done_r;
    logic             any_sat_s;
    logic [4:0]       status_s;
`ifdef HSCNT_SATFLAG_EN
    logic [31:0]      sat_flag_r;
    logic [31:0]      sat_now_s;
`endif

    // Saturating increment: holds at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        logic [CNT_W-1:0] r;
        if (inc && (v != CNT_MAX)) begin
            r = v + CNT_ONE;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Rising-edge detect and per-cycle count qualifiers.
    always_comb begin
        onset_s = halfstrips & ~hs_r;
        multi_s = ((onset_s & (onset_s - 32'd1)) != 32'd0);
        zero_s  = clear || (state_r == ST_CLEAR);
        count_s = (state_r == ST_COUNT);
    end

    // Next value of every strip counter if it were counting this bx.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_nxt_s[i] = sat_inc(cnt_r[i], onset_s[i]);
        end
    end

    // Window FSM next-state logic; clear overrides everything else.
    always_comb begin
        state_s   = state_r;
        win_cnt_s = win_cnt_r;
        if (clear) begin
            state_s = ST_CLEAR;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_s   = ST_COUNT;
                        win_cnt_s = window;
                    end else begin
                        state_s   = state_r;
                    end
                end
                ST_COUNT: begin
                    if (stop || (win_cnt_r == {{(WIN_W-1){1'b0}}, 1'b1})) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_COUNT;
                    end
                    if (win_cnt_r != {WIN_W{1'b0}}) begin
                        win_cnt_s = win_cnt_r - {{(WIN_W-1){1'b0}}, 1'b1};
                    end else begin
                        win_cnt_s = win_cnt_r;
                    end
                end
                ST_CLEAR: state_s = ST_IDLE;
                default:  state_s = ST_IDLE;
            endcase
        end
    end

    // FSM state, window counter and registered status flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            win_cnt_r <= {WIN_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            win_cnt_r <= win_cnt_s;
            busy_r    <= (state_s == ST_COUNT) || (state_s == ST_CLEAR);
            done_r    <= (state_s == ST_DONE);
        end
    end

    // Previous hit map, loaded every bx in every state so persistence never re-counts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hs_r <= 32'd0;
        end else begin
            hs_r <= halfstrips;
        end
    end

    // Strip, event and multi-hit counters: zeroed by clear, accumulate only in COUNT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) cnt_r[i] <= {CNT_W{1'b0}};
            evt_cnt_r   <= {CNT_W{1'b0}};
            multi_cnt_r <= {CNT_W{1'b0}};
        end else if (zero_s) begin
            for (int i = 0; i < 32; i++) cnt_r[i] <= {CNT_W{1'b0}};
            evt_cnt_r   <= {CNT_W{1'b0}};
            multi_cnt_r <= {CNT_W{1'b0}};
        end else if (count_s) begin
            for (int i = 0; i < 32; i++) cnt_r[i] <= cnt_nxt_s[i];
            evt_cnt_r   <= sat_inc(evt_cnt_r, (onset_s != 32'd0));
            multi_cnt_r <= sat_inc(multi_cnt_r, multi_s);
        end
    end

`ifdef HSCNT_SATFLAG_EN
    // Strips whose counter reaches the limit on this edge.
    always_comb begin
        sat_now_s = 32'd0;
        for (int i = 0; i < 32; i++) begin
            sat_now_s[i] = (cnt_nxt_s[i] == CNT_MAX);
        end
    end

    // Sticky per-strip saturation flags; only clear or reset drops them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sat_flag_r <= 32'd0;
        end else if (zero_s) begin
            sat_flag_r <= 32'd0;
        end else if (count_s) begin
            sat_flag_r <= sat_flag_r | sat_now_s;
        end
    end
`endif

    // Saturation summary over every counter.
    always_comb begin
        any_sat_s = (evt_cnt_r == CNT_MAX) || (multi_cnt_r == CNT_MAX);
`ifdef HSCNT_SATFLAG_EN
        any_sat_s = any_sat_s || (sat_flag_r != 32'd0);
`else
        for (int i = 0; i < 32; i++) begin
            any_sat_s = any_sat_s || (cnt_r[i] == CNT_MAX);
        end
`endif
    end

    // Read multiplexer over pre-edge counter values.
    always_comb begin
        status_s = {any_sat_s, done_r, busy_r, state_r};
        rd_s     = {CNT_W{1'b0}};
        if (rd_adr[5] == 1'b0) begin
            rd_s = cnt_r[rd_adr[4:0]];
        end else begin
            case (rd_adr)
                6'd32:   rd_s = evt_cnt_r;
                6'd33:   rd_s = multi_cnt_r;
                6'd34:   rd_s = CNT_W'(status_s);
`ifdef HSCNT_SATFLAG_EN
                6'd35:   rd_s = CNT_W'(sat_flag_r[15:0]);
                6'd36:   rd_s = CNT_W'(sat_flag_r[31:16]);
`endif
                default: rd_s = {CNT_W{1'b0}};
            endcase
        end
    end

    // Registered read data, one clock of latency.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_r <= {CNT_W{1'b0}};
        end else begin
            rd_data_r <= rd_s;
        end
    end

    assign rd_data = rd_data_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign any_sat = any_sat_s;

endmodule

// File: tb/tb_halfstrip_hit_counter.sv
// Self-checking bench for halfstrip_hit_counter (CNT_W = 8 so saturation is reachable).
module tb_halfstrip_hit_counter;

    localparam int CNT_W = 8;
    localparam int WIN_W = 16;
    localparam int MAXV  = (1 << CNT_W) - 1;
    localparam int S_IDLE = 0, S_CNT = 1, S_DONE = 2, S_CLR = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [31:0]      halfstrips = 32'd0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             clear = 1'b0;
    logic [WIN_W-1:0] window = '0;
    logic [5:0]       rd_adr = 6'd0;
    logic [CNT_W-1:0] rd_data;
    logic             busy, done, any_sat;

    int n_checks = 0;
    int n_err    = 0;

    halfstrip_hit_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clock(clock), .reset(reset), .halfstrips(halfstrips),
        .start(start), .stop(stop), .clear(clear), .window(window),
        .rd_adr(rd_adr), .rd_data(rd_data), .busy(busy), .done(done),
        .any_sat(any_sat)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural reference model ----------------
    int          m_cnt [32];
    int          m_evt, m_multi, m_state, m_win, m_rd;
    logic [31:0] m_hsq;

    function automatic int sinc(input int v);
        return (v < MAXV) ? v + 1 : MAXV;
    endfunction

    function automatic bit m_sat();
        bit s = (m_evt == MAXV) || (m_multi == MAXV);
        for (int i = 0; i < 32; i++) if (m_cnt[i] == MAXV) s = 1'b1;
        return s;
    endfunction

    function automatic int m_read(input int adr);
        int v = 0;
        int flags = 0;
        for (int i = 0; i < 32; i++) if (m_cnt[i] == MAXV) flags = flags | (1 << i);
        if (adr < 32)       v = m_cnt[adr];
        else if (adr == 32) v = m_evt;
        else if (adr == 33) v = m_multi;
        else if (adr == 34) v = (int'(m_sat()) << 4) | (int'(m_state == S_DONE) << 3)
                              | (int'(m_state == S_CNT || m_state == S_CLR) << 2) | m_state;
`ifdef HSCNT_SATFLAG_EN
        else if (adr == 35) v = flags & 32'hFFFF;
        else if (adr == 36) v = (flags >> 16) & 32'hFFFF;
`endif
        return v & MAXV;
    endfunction

    // Model advances one bx on each rising edge, or drops everything on reset.
    always @(posedge clock or negedge reset) begin : model
        logic [31:0] on;
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_evt = 0; m_multi = 0; m_state = S_IDLE; m_win = 0; m_rd = 0; m_hsq = 32'd0;
        end else begin
            m_rd  = m_read(int'(rd_adr));
            on    = halfstrips & ~m_hsq;
            m_hsq = halfstrips;
            if (clear || m_state == S_CLR) begin
                for (int i = 0; i < 32; i++) m_cnt[i] = 0;
                m_evt = 0; m_multi = 0;
            end else if (m_state == S_CNT) begin
                for (int i = 0; i < 32; i++) if (on[i]) m_cnt[i] = sinc(m_cnt[i]);
                if (on != 32'd0) m_evt = sinc(m_evt);
                if ($countones(on) >= 2) m_multi = sinc(m_multi);
            end
            if (clear) m_state = S_CLR;
            else if (m_state == S_CLR) m_state = S_IDLE;
            else if (m_state == S_CNT) begin
                if (stop || m_win == 1) m_state = S_DONE;
                if (m_win > 0) m_win = m_win - 1;
            end else if (start) begin
                m_state = S_CNT;
                m_win   = int'(window);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every cycle away from the active edge.
    always @(negedge clock) begin
        if (reset) begin
            check("rd_data", int'(rd_data), m_rd);
            check("busy", int'(busy), int'(m_state == S_CNT || m_state == S_CLR));
            check("done", int'(done), int'(m_state == S_DONE));
            check("any_sat", int'(any_sat), int'(m_sat()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_start(input int w);
        window = WIN_W'(w); start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0; tick();
    endtask

    task automatic rd(input int adr, output int val);
        rd_adr = 6'(adr); tick(); val = int'(rd_data);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < 200) begin tick(); k++; end
        check(name, int'(done), 1);
    endtask

    initial begin
        int v, n;
        logic [31:0] pat;
        repeat (3) tick();
        check("reset_rd", int'(rd_data), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_any_sat", int'(any_sat), 0);
        reset = 1'b1;
        tick();

        // 1: window 10, strip 5 pulses at bx 2, 4, 6
        do_start(10);
        n = 0;
        for (int j = 0; j < 40 && !done; j++) begin
            halfstrips = (j == 2 || j == 4 || j == 6) ? (32'd1 << 5) : 32'd0;
            tick(); n++;
        end
        check("t1_len", n, 10);
        rd(5, v);  check("t1_cnt5", v, 3);
        rd(32, v); check("t1_evt", v, 3);
        rd(33, v); check("t1_multi", v, 0);
        rd(34, v); check("t1_status", v, 8'h0A);

        // 2: persistence, strip 8 high throughout
        halfstrips = 32'd1 << 8;
        do_clear();
        do_start(20);
        for (int j = 0; j < 30 && !done; j++) begin
            halfstrips = (32'd1 << 8) | ((j >= 2 && j < 10) ? (32'd1 << 7) : 32'd0);
            tick();
        end
        check("t2_done", int'(done), 1);
        rd(7, v); check("t2_cnt7", v, 1);
        rd(8, v); check("t2_cnt8", v, 0);
        halfstrips = 32'd0;

        // 3: simultaneous onsets on 9, 10, 11
        do_clear();
        do_start(5);
        halfstrips = 32'h0000_0E00; tick();
        halfstrips = 32'd0;
        wait_done("t3_done");
        rd(10, v); check("t3_cnt10", v, 1);
        rd(32, v); check("t3_evt", v, 1);
        rd(33, v); check("t3_multi", v, 1);

        // 4: open-ended window, accumulation over two windows
        do_clear();
        for (int w = 0; w < 2; w++) begin
            do_start(0);
            repeat (4) begin halfstrips = 32'd1; tick(); halfstrips = 32'd0; tick(); end
            do_stop();
            check("t4_done", int'(done), 1);
            rd(0, v); check("t4_cnt0", v, 4 * (w + 1));
        end

        // 5: clear and start together mid-COUNT
        do_start(0);
        halfstrips = 32'd3; tick(); halfstrips = 32'd0;
        clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
        check("t5_busy_clr", int'(busy), 1);
        tick();
        check("t5_busy_idle", int'(busy), 0);
        rd(0, v);  check("t5_cnt0", v, 0);
        rd(33, v); check("t5_multi", v, 0);
        rd(34, v); check("t5_status", v, 0);

        // 6: saturation on strip 31
        do_start(0);
        repeat (MAXV + 20) begin halfstrips = 32'h8000_0000; tick(); halfstrips = 32'd0; tick(); end
        do_stop();
        rd(31, v); check("t6_cnt31", v, MAXV);
        check("t6_any_sat", int'(any_sat), 1);

        // async reset mid-window
        do_start(0);
        tick();
        #2 reset = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_rd", int'(rd_data), 0);
        check("arst_any_sat", int'(any_sat), 0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            pat        = $urandom() & $urandom() & $urandom();
            halfstrips = pat;
            start      = ($urandom_range(11) == 0);
            stop       = ($urandom_range(19) == 0);
            clear      = ($urandom_range(149) == 0);
            window     = WIN_W'($urandom_range(24));
            rd_adr     = 6'($urandom_range(63));
            tick();
        end
        start = 1'b0; stop = 1'b0; clear = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
